// File: rtl/pixel_split_pkg.sv
// Shared defaults and routing-mode encodings for the pixel splitter.
package pixel_split_pkg;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 4;
   localparam int CW_DEF    = 16;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_THR = 1'b1
   } mode_e;
endpackage

// File: rtl/pixel_split_if.sv
// Valid/ready pixel stream: master drives data/valid, slave drives ready.
interface pixel_split_if
   import pixel_split_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic [DW-1:0] data;
   logic          valid;
   logic          ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pixel_fifo.sv
// First-word-fall-through pixel FIFO; head visible one cycle after a push into an empty FIFO.
// Push is ignored while full; push and pop may coincide at any non-full occupancy.
module pixel_fifo
   import pixel_split_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   output logic          full,
   pixel_split_if.master deq
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   // Pointer MSB is the wrap bit that tells full apart from empty.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = deq.ready && !empty;

   assign deq.valid = !empty;
   assign deq.data  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rptr <= rptr + (AW+1)'(1);
         end
      end
   end
endmodule

// File: rtl/pixel_split.sv
// Routes each accepted pixel to FIFO A or B (by select bit or threshold) and counts per-output accepts.
// One-cycle latency; input stalls whenever either FIFO is full.
module pixel_split
   import pixel_split_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   pixel_split_if.slave  in_if,
   input  logic          mode,
   input  logic          in_sel,
   input  logic [DW-1:0] thresh,
   pixel_split_if.master a_if,
   pixel_split_if.master b_if,
   input  logic          clr,
   output logic [CW-1:0] cnt_a,
   output logic [CW-1:0] cnt_b
);
   logic a_full;
   logic b_full;
   logic to_b;
   logic accept;
   logic push_a;
   logic push_b;

   // Ready depends only on FIFO state so upstream never sees a data-dependent stall.
   assign in_if.ready = !a_full && !b_full;
   assign accept      = in_if.valid && in_if.ready;
   assign to_b        = (mode == MODE_THR) ? (in_if.data >= thresh) : in_sel;
   assign push_a      = accept && !to_b;
   assign push_b      = accept && to_b;

   pixel_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_a),
      .push_data (in_if.data),
      .full      (a_full),
      .deq       (a_if)
   );

   pixel_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_b),
      .push_data (in_if.data),
      .full      (b_full),
      .deq       (b_if)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (clr) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (push_a) cnt_a <= cnt_a + CW'(1);
         if (push_b) cnt_b <= cnt_b + CW'(1);
      end
   end
endmodule

// File: tb/tb_pixel_split.sv
// Directed bench for pixel_split with narrow counters so wrap-around is reachable.
module tb_pixel_split;
   import pixel_split_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode;
   logic          in_sel;
   logic          clr;
   logic [DW-1:0] thresh;
   logic [CW-1:0] cnt_a;
   logic [CW-1:0] cnt_b;

   pixel_split_if #(.DW(DW)) in_if ();
   pixel_split_if #(.DW(DW)) a_if ();
   pixel_split_if #(.DW(DW)) b_if ();

   pixel_split #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_if  (in_if),
      .mode   (mode),
      .in_sel (in_sel),
      .thresh (thresh),
      .a_if   (a_if),
      .b_if   (b_if),
      .clr    (clr),
      .cnt_a  (cnt_a),
      .cnt_b  (cnt_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic s);
      in_if.data  = d;
      in_sel      = s;
      in_if.valid = 1'b1;
      tick();
      in_if.valid = 1'b0;
   endtask

   initial begin
      int            sent;
      int            cyc;
      bit            first;
      logic [31:0]   exp_d;
      logic [DW-1:0] d;

      rst_n       = 1'b0;
      mode        = 1'b0;
      in_sel      = 1'b0;
      clr         = 1'b0;
      thresh      = '0;
      in_if.valid = 1'b0;
      in_if.data  = '0;
      a_if.ready  = 1'b0;
      b_if.ready  = 1'b0;

      // Reset state
      #2;
      check("rst_a_valid", 32'(a_if.valid), 0);
      check("rst_b_valid", 32'(b_if.valid), 0);
      check("rst_a_data", 32'(a_if.data), 0);
      check("rst_b_data", 32'(b_if.data), 0);
      check("rst_cnt_a", 32'(cnt_a), 0);
      check("rst_cnt_b", 32'(cnt_b), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_if.ready), 1);

      // Select-bit routing, both outputs draining
      a_if.ready = 1'b1;
      b_if.ready = 1'b1;
      mode       = 1'b0;
      send(8'h10, 1'b0);
      check("sel_a_valid1", 32'(a_if.valid), 1);
      check("sel_a_data1", 32'(a_if.data), 32'h10);
      send(8'h20, 1'b1);
      check("sel_a_valid2", 32'(a_if.valid), 0);
      check("sel_b_valid2", 32'(b_if.valid), 1);
      check("sel_b_data2", 32'(b_if.data), 32'h20);
      send(8'h30, 1'b0);
      check("sel_a_data3", 32'(a_if.data), 32'h30);
      check("sel_b_valid3", 32'(b_if.valid), 0);
      tick();
      check("sel_a_drained", 32'(a_if.valid), 0);
      check("sel_cnt_a", 32'(cnt_a), 2);
      check("sel_cnt_b", 32'(cnt_b), 1);

      // Threshold routing; in_sel must be ignored
      a_if.ready = 1'b0;
      b_if.ready = 1'b0;
      mode       = 1'b1;
      thresh     = 8'h80;
      send(8'h7F, 1'b1);
      send(8'h80, 1'b0);
      send(8'hFF, 1'b0);
      send(8'h00, 1'b1);
      check("thr_a_head", 32'(a_if.data), 32'h7F);
      check("thr_b_head", 32'(b_if.data), 32'h80);
      tick();
      check("thr_a_stable", 32'(a_if.data), 32'h7F);
      check("thr_b_stable", 32'(b_if.data), 32'h80);
      a_if.ready = 1'b1;
      b_if.ready = 1'b1;
      tick();
      check("thr_a_next", 32'(a_if.data), 32'h00);
      check("thr_b_next", 32'(b_if.data), 32'hFF);
      tick();
      check("thr_a_empty", 32'(a_if.valid), 0);
      check("thr_b_empty", 32'(b_if.valid), 0);
      check("thr_cnt_a", 32'(cnt_a), 4);
      check("thr_cnt_b", 32'(cnt_b), 3);
      a_if.ready = 1'b0;
      b_if.ready = 1'b0;
      mode       = 1'b0;

      // Fill B while stalled; A must still drain independently
      send(8'h55, 1'b0);
      send(8'h41, 1'b1);
      send(8'h42, 1'b1);
      send(8'h43, 1'b1);
      check("bfull_in_ready3", 32'(in_if.ready), 1);
      send(8'h44, 1'b1);
      check("bfull_in_ready4", 32'(in_if.ready), 0);
      check("bfull_b_valid", 32'(b_if.valid), 1);
      check("bfull_b_head", 32'(b_if.data), 32'h41);
      in_if.data  = 8'h99;
      in_sel      = 1'b1;
      in_if.valid = 1'b1;
      a_if.ready  = 1'b1;
      tick();
      in_if.valid = 1'b0;
      check("bfull_no_accept", 32'(cnt_b), 7);
      check("bfull_a_popped", 32'(a_if.valid), 0);
      a_if.ready = 1'b0;
      b_if.ready = 1'b1;
      tick();
      check("bdrain_in_ready", 32'(in_if.ready), 1);
      check("bdrain_d42", 32'(b_if.data), 32'h42);
      tick();
      check("bdrain_d43", 32'(b_if.data), 32'h43);
      tick();
      check("bdrain_d44", 32'(b_if.data), 32'h44);
      tick();
      check("bdrain_empty", 32'(b_if.valid), 0);
      b_if.ready = 1'b0;

      // Fill A, then pop on the full cycle and stream 20 random pixels
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'hA0 + 8'(i);
         send(d, 1'b0);
         sb.push_back(d);
      end
      check("afull_in_ready", 32'(in_if.ready), 0);
      check("afull_cnt_a", 32'(cnt_a), 9);
      sent  = 0;
      cyc   = 0;
      first = 1'b1;
      while ((sent < 20 || sb.size() > 0) && cyc < 300) begin
         a_if.ready = first ? 1'b1 : ($urandom_range(0, 3) != 0);
         in_sel     = 1'b0;
         if (sent < 20) begin
            in_if.valid = 1'b1;
            in_if.data  = 8'($urandom_range(0, 255));
         end else begin
            in_if.valid = 1'b0;
         end
         if (first) check("afull_pop_in_ready", 32'(in_if.ready), 0);
         if (a_if.valid && a_if.ready) begin
            exp_d = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD;
            check("a_order", 32'(a_if.data), exp_d);
         end
         if (in_if.valid && in_if.ready) begin
            sb.push_back(in_if.data);
            sent++;
         end
         tick();
         if (first) begin
            check("afull_next_in_ready", 32'(in_if.ready), 1);
            first = 1'b0;
         end
         cyc++;
      end
      in_if.valid = 1'b0;
      a_if.ready  = 1'b0;
      check("rand_sent", 32'(sent), 20);
      check("rand_sb_empty", 32'(sb.size()), 0);
      check("rand_a_empty", 32'(a_if.valid), 0);
      check("rand_cnt_a_wrap", 32'(cnt_a), 13);

      // Counter clear, wrap at 2^CW, and clear winning over an accept
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_cnt_a", 32'(cnt_a), 0);
      check("clr_cnt_b", 32'(cnt_b), 0);
      a_if.ready  = 1'b1;
      in_sel      = 1'b0;
      in_if.valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_if.data = 8'(i);
         tick();
      end
      in_if.valid = 1'b0;
      check("wrap_cnt_a", 32'(cnt_a), 1);
      tick();
      in_if.data  = 8'h5A;
      in_if.valid = 1'b1;
      clr         = 1'b1;
      tick();
      in_if.valid = 1'b0;
      clr         = 1'b0;
      check("clr_acc_cnt_a", 32'(cnt_a), 0);
      check("clr_acc_cnt_b", 32'(cnt_b), 0);
      check("clr_acc_a_data", 32'(a_if.data), 32'h5A);
      tick();
      check("clr_acc_a_empty", 32'(a_if.valid), 0);

      // Mid-stream reset discards buffered pixels
      a_if.ready = 1'b0;
      b_if.ready = 1'b0;
      send(8'h11, 1'b0);
      send(8'h22, 1'b1);
      send(8'h33, 1'b0);
      check("pre_rst_a_valid", 32'(a_if.valid), 1);
      check("pre_rst_b_valid", 32'(b_if.valid), 1);
      check("pre_rst_cnt_a", 32'(cnt_a), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_a_valid", 32'(a_if.valid), 0);
      check("mid_rst_b_valid", 32'(b_if.valid), 0);
      check("mid_rst_cnt_a", 32'(cnt_a), 0);
      check("mid_rst_cnt_b", 32'(cnt_b), 0);
      check("mid_rst_a_data", 32'(a_if.data), 0);
      tick();
      rst_n      = 1'b1;
      a_if.ready = 1'b1;
      b_if.ready = 1'b1;
      tick();
      tick();
      check("post_rst_a_valid", 32'(a_if.valid), 0);
      check("post_rst_b_valid", 32'(b_if.valid), 0);
      check("post_rst_in_ready", 32'(in_if.ready), 1);
      check("post_rst_b_data", 32'(b_if.data), 0);
      b_if.ready = 1'b0;
      send(8'h77, 1'b1);
      check("post_rst_new_b_valid", 32'(b_if.valid), 1);
      check("post_rst_new_b_data", 32'(b_if.data), 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pixel_split.md
PIXEL_SPLIT -- requirements
Module: pixel_split

Interface
REQ-001 Parameter DW, default 8, pixel data width.
REQ-002 Parameter DEPTH, default 4, entries per output FIFO (power of two, >=2).
REQ-003 Parameter CW, default 16, width of each routed-pixel counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DW  incoming pixel.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts a pixel this cycle.
REQ-009 mode  input  1  0 = route by in_sel, 1 = route by threshold.
REQ-010 in_sel  input  1  destination in mode 0 (0 = A, 1 = B); sampled with in_data.
REQ-011 thresh  input  DW  threshold in mode 1 (in_data >= thresh -> B, else A).
REQ-012 a_data / b_data  output  DW  head pixel of FIFO A / B.
REQ-013 a_valid / b_valid  output  1  FIFO A / B non-empty.
REQ-014 a_ready / b_ready  input  1  downstream consumes the head of A / B.
REQ-015 clr  input  1  synchronous clear of both counters.
REQ-016 cnt_a / cnt_b  output  CW  pixels accepted into A / B since reset or clr.

Function
REQ-017 A transfer on any port SHALL occur only on a cycle where its valid and ready are both high.
REQ-018 in_ready SHALL be high iff neither FIFO is full, independent of in_data, in_sel and mode.
REQ-019 Each accepted pixel SHALL be pushed into exactly one FIFO, as selected per REQ-010/REQ-011, unsigned compare.
REQ-020 Latency SHALL be one cycle: a pixel accepted into an empty FIFO appears on x_data with x_valid high on the next cycle.
REQ-021 FIFOs SHALL be first-word-fall-through; x_data SHALL hold stable while x_valid high and x_ready low.
REQ-022 Simultaneous push and pop on one FIFO SHALL be allowed at any non-full occupancy; occupancy is unchanged.
REQ-023 A pop on an empty FIFO (x_ready with x_valid low) SHALL have no effect.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished via an extra pointer bit.
REQ-025 Pixel order within each output SHALL equal arrival order; outputs are independent (A stalled SHALL not block B pops).
REQ-026 cnt_x SHALL increment by one per pixel accepted into FIFO x and wrap from 2^CW-1 to 0.
REQ-027 clr SHALL zero both counters; if clr coincides with an accept, the counter SHALL be 0 afterwards (clr wins).
REQ-028 mode, in_sel and thresh changes SHALL affect only pixels accepted on or after the change cycle.

Reset
REQ-029 rst_n low SHALL immediately force: both FIFOs empty, a_valid = b_valid = 0, cnt_a = cnt_b = 0, in_ready = 1 after release.
REQ-030 Reset mid-stream SHALL discard all buffered pixels; no pixel SHALL appear on outputs after release until newly accepted.
REQ-031 a_data / b_data SHALL read 0 during and after reset until the first push.

Structure
REQ-032 Package pixel_split_pkg SHALL hold DW/DEPTH/CW defaults and mode encodings (MODE_SEL = 0, MODE_THR = 1).
REQ-033 One sub-module pixel_fifo (FWFT, parameters DW and DEPTH) SHALL be instantiated twice (A and B).
REQ-034 Routing, in_ready generation and counters SHALL live in pixel_split top.

Verification
REQ-035 Mode 0, send 0x10(sel0), 0x20(sel1), 0x30(sel0), both ready high -> A emits 0x10,0x30; B emits 0x20; cnt_a=2, cnt_b=1.
REQ-036 Mode 1, thresh=0x80, send 0x7F,0x80,0xFF,0x00 -> A: 0x7F,0x00; B: 0x80,0xFF.
REQ-037 b_ready low, send 4 pixels to B -> b_valid high, in_ready low after 4th; next cycle b_ready high -> in_ready high, order preserved.
REQ-038 A full, simultaneous pop on A -> in_ready low that cycle, high next; no pixel lost or duplicated across 20 random pixels.
REQ-039 CW=4, 17 pixels to A -> cnt_a = 1; clr asserted with an accept -> cnt = 0.
REQ-040 Assert rst_n low with 3 pixels buffered -> a_valid=b_valid=0, counters 0 immediately; after release outputs stay empty until new input.
